// File: rtl/mole_round_scheduler.sv
// Whack-a-mole game sequencer: spawns one pseudo-random mole per tick, judges presses,
// keeps score and misses, steps the trigger difficulty and ends the game after too many misses.
module mole_round_scheduler #(
  parameter int          NUM_HOLES     = 4,
  parameter int          SCORE_W       = 8,
  parameter int          MAX_MISSES    = 3,
  parameter int          LEVEL_UP_HITS = 5,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [1:0]           difficulty,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           misses,
  output logic                 game_over,
  output logic                 busy
);

  localparam int         IDX_W      = $clog2(NUM_HOLES);
  localparam logic [3:0] MAX_MISS_C = 4'(MAX_MISSES);
  localparam logic [3:0] LVL_HITS_C = 4'(LEVEL_UP_HITS);
  localparam logic [1:0] DIFF_TOP   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_UP,
    S_OVER
  } state_e;

  state_e                 state_q;
  logic [7:0]             lfsr_q;
  logic [IDX_W-1:0]       prev_idx_q;
  logic [3:0]             lvl_hits_q;
  logic [NUM_HOLES-1:0]   mole_q;
  logic [SCORE_W-1:0]     score_q;
  logic [3:0]             misses_q;
  logic [1:0]             difficulty_q;
  logic                   game_over_q;

  logic                   lfsr_fb;
  logic [IDX_W-1:0]       raw_idx;
  logic [IDX_W-1:0]       spawn_idx_d;
  logic [NUM_HOLES-1:0]   spawn_mole_d;
  logic                   hit;

  // Taps x^8+x^6+x^5+x^4+1; a nonzero seed keeps the register out of the all-zero lockup.
  assign lfsr_fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign raw_idx      = lfsr_q[IDX_W-1:0];
  // Power-of-two hole count makes the +1 wrap naturally, so a repeat hole is never spawned.
  assign spawn_idx_d  = (raw_idx == prev_idx_q) ? IDX_W'(raw_idx + 1'b1) : raw_idx;
  assign spawn_mole_d = {{(NUM_HOLES-1){1'b0}}, 1'b1} << spawn_idx_d;
  assign hit          = |(btn & mole_q);

  // NOTE: all state updates use non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      prev_idx_q   <= '0;
      lvl_hits_q   <= '0;
      mole_q       <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      difficulty_q <= '0;
      game_over_q  <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q      <= S_ARM;
            score_q      <= '0;
            misses_q     <= '0;
            lvl_hits_q   <= '0;
            difficulty_q <= '0;
            mole_q       <= '0;
            game_over_q  <= 1'b0;
          end
        end
        S_ARM: begin
          if (tick) begin
            state_q    <= S_UP;
            mole_q     <= spawn_mole_d;
            prev_idx_q <= spawn_idx_d;
          end
        end
        S_UP: begin
          // A hit outranks a tick arriving in the same cycle.
          if (hit) begin
            state_q <= S_ARM;
            mole_q  <= '0;
            if (!(&score_q)) score_q <= score_q + 1'b1;
            if (lvl_hits_q + 4'd1 == LVL_HITS_C) begin
              lvl_hits_q <= '0;
              if (difficulty_q != DIFF_TOP) difficulty_q <= difficulty_q + 2'd1;
            end else begin
              lvl_hits_q <= lvl_hits_q + 4'd1;
            end
          end else if (tick) begin
            mole_q   <= '0;
            misses_q <= misses_q + 4'd1;
            if (misses_q + 4'd1 == MAX_MISS_C) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_ARM;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign difficulty = difficulty_q;
  assign mole       = mole_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign game_over  = game_over_q;
  assign busy       = (state_q == S_ARM) || (state_q == S_UP);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: directed game scenarios followed by random play,
// all checked against a game-level reference model.
module tb_mole_round_scheduler;

  localparam int         N     = 4;
  localparam int         SW    = 3;
  localparam int         MAXM  = 3;
  localparam int         LVLH  = 5;
  localparam logic [7:0] SEED  = 8'hA5;
  localparam int         SMAX  = (1 << SW) - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          tick;
  logic [N-1:0]  btn;
  logic [1:0]    difficulty;
  logic [N-1:0]  mole;
  logic [SW-1:0] score;
  logic [3:0]    misses;
  logic          game_over;
  logic          busy;

  mole_round_scheduler #(
    .NUM_HOLES(N), .SCORE_W(SW), .MAX_MISSES(MAXM), .LEVEL_UP_HITS(LVLH), .LFSR_SEED(SEED)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .start     (start),
    .tick      (tick),
    .btn       (btn),
    .difficulty(difficulty),
    .mole      (mole),
    .score     (score),
    .misses    (misses),
    .game_over (game_over),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game-level model: the game is either in progress or not, a mole is a hole number or -1,
  // and score/difficulty follow from the total hits of the current game.
  bit         m_active;
  bit         m_over;
  int         m_mole;
  int         m_prev;
  int         m_hits;
  int         m_misses;
  logic [7:0] m_lfsr;

  int tests_run;
  int fail_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit tk, input logic [N-1:0] b);
    logic [7:0] cur;
    int         idx;
    cur    = m_lfsr;
    m_lfsr = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    if (rst) begin
      m_active = 0; m_over = 0; m_mole = -1; m_prev = 0;
      m_hits = 0; m_misses = 0; m_lfsr = SEED;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_over = 0; m_hits = 0; m_misses = 0; m_mole = -1;
      end
    end else if (m_mole < 0) begin
      if (tk) begin
        idx = int'(cur) % N;
        if (idx == m_prev) idx = (idx + 1) % N;
        m_mole = idx;
        m_prev = idx;
      end
    end else if (b[m_mole]) begin
      m_hits++;
      m_mole = -1;
    end else if (tk) begin
      m_misses++;
      m_mole = -1;
      if (m_misses == MAXM) begin
        m_active = 0;
        m_over   = 1;
      end
    end
  endtask

  task automatic compare_all();
    int exp_score, exp_diff;
    exp_score = (m_hits > SMAX) ? SMAX : m_hits;
    exp_diff  = (m_hits / LVLH > 2) ? 2 : m_hits / LVLH;
    check("mole",       32'(mole),       (m_mole < 0) ? 32'd0 : 32'(1 << m_mole));
    check("score",      32'(score),      32'(exp_score));
    check("misses",     32'(misses),     32'(m_misses));
    check("difficulty", 32'(difficulty), 32'(exp_diff));
    check("game_over",  32'(game_over),  32'(m_over));
    check("busy",       32'(busy),       32'(m_active));
    check("diff_not_11", 32'(difficulty == 2'b11), 32'd0);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit tk, input logic [N-1:0] b);
    @(negedge clk);
    reset = rst; start = st; tick = tk; btn = b;
    @(posedge clk);
    model_step(rst, st, tk, b);
    #1;
    compare_all();
  endtask

  function automatic logic [N-1:0] hole_bit(input int h);
    return N'(1 << h);
  endfunction

  task automatic spawn();
    cycle(0, 0, 1, '0);
    check("spawn_onehot", 32'($countones(mole)), 32'd1);
  endtask

  task automatic hit_one();
    spawn();
    cycle(0, 0, 0, hole_bit(m_mole));
  endtask

  int last_spawn;

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    reset = 1'b1; start = 1'b0; tick = 1'b0; btn = '0;

    // Reset state
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    check("reset_mole", 32'(mole), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Idle ignores tick/btn, then start and first hit
    cycle(0, 0, 1, 4'hF);
    cycle(0, 1, 0, '0);
    check("start_busy", 32'(busy), 32'd1);
    cycle(0, 0, 0, 4'hF);
    spawn();
    cycle(0, 0, 0, hole_bit(m_mole));
    check("first_hit_score", 32'(score), 32'd1);
    check("first_hit_mole", 32'(mole), 32'd0);
    check("first_hit_busy", 32'(busy), 32'd1);

    // Hit and tick together: hit wins
    spawn();
    cycle(0, 0, 1, hole_bit(m_mole));
    check("hit_tick_score", 32'(score), 32'd2);
    check("hit_tick_misses", 32'(misses), 32'd0);

    // Wrong button ignored, start ignored mid-game
    spawn();
    cycle(0, 0, 0, ~hole_bit(m_mole));
    cycle(0, 1, 0, '0);
    check("wrong_btn_score", 32'(score), 32'd2);
    check("wrong_btn_mole_held", 32'($countones(mole)), 32'd1);
    cycle(0, 0, 0, hole_bit(m_mole));

    // Three misses end the game; OVER ignores tick/btn
    repeat (MAXM) begin
      spawn();
      cycle(0, 0, 1, '0);
    end
    check("over_misses", 32'(misses), 32'd3);
    check("over_flag", 32'(game_over), 32'd1);
    repeat (3) cycle(0, 0, 1, 4'hF);
    check("over_hold_score", 32'(score), 32'd3);
    cycle(0, 1, 0, '0);
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_score", 32'(score), 32'd0);
    check("restart_misses", 32'(misses), 32'd0);

    // Difficulty steps and score saturation
    for (int i = 1; i <= 15; i++) begin
      hit_one();
      if (i == 5)  check("diff_after_5", 32'(difficulty), 32'd1);
      if (i == 9)  check("score_sat_9", 32'(score), 32'd7);
      if (i == 10) check("diff_after_10", 32'(difficulty), 32'd2);
      if (i == 15) check("diff_after_15", 32'(difficulty), 32'd2);
    end

    // 100 spawns: one-hot and never the same hole twice in a row
    last_spawn = -1;
    for (int i = 0; i < 100; i++) begin
      spawn();
      check("no_repeat", 32'(m_mole != last_spawn && mole != hole_bit(last_spawn < 0 ? 0 : last_spawn)
                              || last_spawn < 0), 32'd1);
      last_spawn = m_mole;
      cycle(0, 0, 0, hole_bit(m_mole));
    end

    // Reset mid-UP wins over a matching press
    spawn();
    cycle(1, 0, 0, hole_bit(m_mole));
    check("midup_reset_mole", 32'(mole), 32'd0);
    check("midup_reset_score", 32'(score), 32'd0);

    // Random play
    for (int i = 0; i < 800; i++) begin
      bit            r_rst, r_st, r_tk;
      logic [N-1:0]  r_b;
      r_rst = ($urandom_range(0, 149) == 0);
      r_st  = ($urandom_range(0, 7) == 0);
      r_tk  = ($urandom_range(0, 2) == 0);
      r_b   = '0;
      if (m_mole >= 0 && $urandom_range(0, 2) == 0) r_b = hole_bit(m_mole);
      else if ($urandom_range(0, 3) == 0)           r_b = N'($urandom);
      cycle(r_rst, r_st, r_tk, r_b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
